nios2_oci_trace_monitor: RTL and testbench

Parametrised debug-trace capture monitor for the Nios II OCI.
- Captures packed DCT trace frames (up to SLOTS slots of SLOT_W bits, plus a valid-slot count) into a circular frame buffer during a test run.
- On test_ending, serialises the captured valid slots one per handshake on a ready/valid readout port, then signals test_has_ended.
- Sits beside the OCI trace path in simulation and emulation builds; its readout feeds the bench scoreboard or a JTAG debug sink.

---
 rtl/nios2_oci_trace_pkg.sv | 24 ++
 rtl/nios2_oci_trace_frame_fifo.sv | 66 ++++++
 rtl/nios2_oci_trace_monitor.sv | 145 ++++++++++++++
 tb/tb_nios2_oci_trace_monitor.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_oci_trace_pkg.sv
// Shared state encoding and sizing helpers for the Nios II OCI trace monitor.
package nios2_oci_trace_pkg;

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        DRAIN   = 2'd1,
        ENDED   = 2'd2
    } trace_state_e;

    // Bits needed for a clamped slot count in the range 0..slots.
    function automatic int slot_cnt_w(input int slots);
        return $clog2(slots + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // A stored frame is {clamped count, packed slots}.
    function automatic int entry_w(input int slot_w, input int slots);
        return slot_w * slots + slot_cnt_w(slots);
    endfunction

endpackage

// File: rtl/nios2_oci_trace_frame_fifo.sv
// Circular DEPTH-entry frame store; write and pop take effect at the clock edge.
// When full, a write is either discarded or replaces the oldest entry (OVERWRITE).
module nios2_oci_trace_frame_fifo
    import nios2_oci_trace_pkg::*;
#(
    parameter int ENTRY_W   = 32,
    parameter int DEPTH     = 16,
    parameter bit OVERWRITE = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   wr_vld_i,
    input  logic [ENTRY_W-1:0]     wr_dat_i,
    input  logic                   rd_pop_i,
    output logic [ENTRY_W-1:0]     rd_dat_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   dropped_o
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]      count_q, count_d;
    logic               full, pop_ok, wr_ok, ovw;

    assign full    = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pop_ok  = rd_pop_i && !empty_o;
    assign wr_ok   = wr_vld_i && (!full || pop_ok);
    // Overwrite moves head and tail together, so occupancy stays at DEPTH.
    assign ovw     = wr_vld_i && full && !pop_ok && OVERWRITE;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop_ok || ovw) head_d = head_q + 1'b1;
        if (wr_ok || ovw)  tail_d = tail_q + 1'b1;
        if (wr_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (pop_ok && !wr_ok) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok || ovw) mem_q[tail_q] <= wr_dat_i;
    end

    assign rd_dat_o  = mem_q[head_q];
    assign count_o   = count_q;
    assign dropped_o = wr_vld_i && full && !pop_ok;

endmodule

// File: rtl/nios2_oci_trace_monitor.sv
// Trace frame capture then ready/valid slot readout; NIOS2_OCI_TRACE_MON_STATS_EN adds frame counters.
// First slot two cycles after test_ending; rd_data/rd_valid registered and held while rd_ready is low.
module nios2_oci_trace_monitor
    import nios2_oci_trace_pkg::*;
#(
    parameter int SLOT_W    = 10,
    parameter int SLOTS     = 3,
    parameter int CNT_W     = 4,
    parameter int DEPTH     = 16,
    parameter bit OVERWRITE = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SLOT_W*SLOTS-1:0] dct_buffer,
    input  logic [CNT_W-1:0]        dct_count,
    input  logic                    dct_valid,
    input  logic                    test_ending,
    output logic [SLOT_W-1:0]       rd_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic                    test_has_ended,
    output logic                    overflow,
`ifdef NIOS2_OCI_TRACE_MON_STATS_EN
    output logic [31:0]             frames_captured,
    output logic [31:0]             frames_dropped,
`endif
    output logic [$clog2(DEPTH):0]  frames_held
);

    localparam int SC_W  = slot_cnt_w(SLOTS);
    localparam int BUF_W = SLOT_W * SLOTS;
    localparam int EW    = entry_w(SLOT_W, SLOTS);

    trace_state_e      state_q, state_d;
    logic [SC_W-1:0]   slot_idx_q, slot_idx_d;
    logic [SLOT_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q;

    logic [SC_W-1:0]   cnt_clamp;
    logic              fifo_wr_vld, fifo_pop, fifo_empty, fifo_dropped, load_ok;
    logic [EW-1:0]     fifo_rd_dat;
    logic [SC_W-1:0]   h_cnt;
    logic [SLOT_W-1:0] h_slots [SLOTS];

    assign cnt_clamp   = (dct_count > CNT_W'(SLOTS)) ? SC_W'(SLOTS) : SC_W'(dct_count);
    assign fifo_wr_vld = dct_valid && (state_q == CAPTURE);

    nios2_oci_trace_frame_fifo #(
        .ENTRY_W   (EW),
        .DEPTH     (DEPTH),
        .OVERWRITE (OVERWRITE)
    ) u_frame_fifo (
        .clk_i     (clk),
        .reset_i   (reset),
        .wr_vld_i  (fifo_wr_vld),
        .wr_dat_i  ({cnt_clamp, dct_buffer}),
        .rd_pop_i  (fifo_pop),
        .rd_dat_o  (fifo_rd_dat),
        .empty_o   (fifo_empty),
        .count_o   (frames_held),
        .dropped_o (fifo_dropped)
    );

    assign h_cnt = fifo_rd_dat[EW-1 -: SC_W];
    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        assign h_slots[g] = fifo_rd_dat[g*SLOT_W +: SLOT_W];
    end

    // The output register may take a new slot when empty or being accepted this cycle.
    assign load_ok = !rd_valid_q || rd_ready;

    always_comb begin
        state_d    = state_q;
        slot_idx_d = slot_idx_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        fifo_pop   = 1'b0;
        case (state_q)
            CAPTURE: if (test_ending) state_d = DRAIN;
            DRAIN: begin
                if (load_ok) begin
                    rd_valid_d = 1'b0;
                    if (fifo_empty) begin
                        state_d = ENDED;
                    end else if (h_cnt == '0) begin
                        fifo_pop = 1'b1;
                    end else begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = h_slots[slot_idx_q];
                        if (slot_idx_q + 1'b1 == h_cnt) begin
                            fifo_pop   = 1'b1;
                            slot_idx_d = '0;
                        end else begin
                            slot_idx_d = slot_idx_q + 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CAPTURE;
            slot_idx_q <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_idx_q <= slot_idx_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            if (fifo_dropped) overflow_q <= 1'b1;
        end
    end

    assign rd_data        = rd_data_q;
    assign rd_valid       = rd_valid_q;
    assign test_has_ended = (state_q == ENDED);
    assign overflow       = overflow_q;

`ifdef NIOS2_OCI_TRACE_MON_STATS_EN
    logic [31:0] cap_cnt_q, drop_cnt_q;
    logic        fifo_stored;

    assign fifo_stored = fifo_wr_vld && !(fifo_dropped && !OVERWRITE);

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (fifo_stored && cap_cnt_q != '1)   cap_cnt_q  <= cap_cnt_q + 1'b1;
            if (fifo_dropped && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign frames_captured = cap_cnt_q;
    assign frames_dropped  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_nios2_oci_trace_monitor.sv
// Bench for nios2_oci_trace_monitor: drop-new and overwrite-oldest instances share stimulus,
// each checked against a frame-queue reference model.
module tb_nios2_oci_trace_monitor;

    localparam int SLOT_W = 10;
    localparam int SLOTS  = 3;
    localparam int DEPTH  = 16;

    logic        clk = 1'b0;
    logic        reset, dct_valid, test_ending, rd_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic [9:0]  rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1, ended0, ended1, ovf0, ovf1;
    logic [4:0]  held0, held1;
`ifdef NIOS2_OCI_TRACE_MON_STATS_EN
    logic [31:0] fcap0, fdrop0, fcap1, fdrop1;
`endif

    always #5 clk = ~clk;

    nios2_oci_trace_monitor #(.OVERWRITE(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .dct_valid(dct_valid), .test_ending(test_ending), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .rd_ready(rd_ready), .test_has_ended(ended0),
        .overflow(ovf0),
`ifdef NIOS2_OCI_TRACE_MON_STATS_EN
        .frames_captured(fcap0), .frames_dropped(fdrop0),
`endif
        .frames_held(held0)
    );

    nios2_oci_trace_monitor #(.OVERWRITE(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .dct_valid(dct_valid), .test_ending(test_ending), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .rd_ready(rd_ready), .test_has_ended(ended1),
        .overflow(ovf1),
`ifdef NIOS2_OCI_TRACE_MON_STATS_EN
        .frames_captured(fcap1), .frames_dropped(fdrop1),
`endif
        .frames_held(held1)
    );

    typedef struct {
        int          cnt;
        logic [29:0] data;
    } frame_t;

    frame_t mq0[$];
    frame_t mq1[$];
    bit     movf [2];
    int     mcap [2];
    int     mdrop[2];
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        mq0.delete();
        mq1.delete();
        for (int i = 0; i < 2; i++) begin
            movf[i]  = 1'b0;
            mcap[i]  = 0;
            mdrop[i] = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; dct_valid = 1'b0; test_ending = 1'b0; rd_ready = 1'b0;
        step();
        step();
        model_clear();
        chk("rst_vld0", rd_valid0, 0);  chk("rst_vld1", rd_valid1, 0);
        chk("rst_end0", ended0, 0);     chk("rst_end1", ended1, 0);
        chk("rst_ovf0", ovf0, 0);       chk("rst_held0", held0, 0);
        chk("rst_data0", rd_data0, 0);
        reset = 1'b0;
    endtask

    // Reference: queue of frames per instance; full drops the new frame or evicts the oldest.
    task automatic cap(input int cnt, input logic [29:0] d, input bit te);
        frame_t f, old;
        dct_valid = 1'b1; dct_count = cnt[3:0]; dct_buffer = d; test_ending = te;
        step();
        dct_valid = 1'b0; test_ending = 1'b0;
        f.cnt  = (cnt > SLOTS) ? SLOTS : cnt;
        f.data = d;
        if (mq0.size() < DEPTH) begin
            mq0.push_back(f); mcap[0]++;
        end else begin
            movf[0] = 1'b1; mdrop[0]++;
        end
        if (mq1.size() >= DEPTH) begin
            old = mq1.pop_front();
            movf[1] = 1'b1; mdrop[1]++;
        end
        mq1.push_back(f); mcap[1]++;
        chk("cap_held0", held0, mq0.size()); chk("cap_held1", held1, mq1.size());
        chk("cap_ovf0", ovf0, movf[0]);      chk("cap_ovf1", ovf1, movf[1]);
`ifdef NIOS2_OCI_TRACE_MON_STATS_EN
        chk("cap_fcap0", fcap0, mcap[0]);    chk("cap_fdrop0", fdrop0, mdrop[0]);
        chk("cap_fcap1", fcap1, mcap[1]);    chk("cap_fdrop1", fdrop1, mdrop[1]);
`endif
    endtask

    // mode 0: always ready; 1: random ready plus noise on ignored inputs; 2: ready low cycles 3..7.
    // Cycle c counts from the edge that sampled test_ending (c = 1 on entry to the loop).
    task automatic drain(input bit pulse, input int mode, input int stop_hs, output int end_c);
        int          nexp[2], idx[2], lead[2], trail[2], nfr[2], last_hs[2], exp_end;
        logic [9:0]  exps[2][64];
        logic [9:0]  hv[2], d[2];
        logic [29:0] fd;
        bit          started[2], held[2], done[2], v[2], e[2];
        frame_t      q[$];
        end_c = -1;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) q = mq0; else q = mq1;
            nexp[i] = 0; idx[i] = 0; lead[i] = 0; trail[i] = 0; nfr[i] = q.size();
            last_hs[i] = 0; started[i] = 0; held[i] = 0; done[i] = 0; hv[i] = '0;
            for (int f = 0; f < q.size(); f++) begin
                if (q[f].cnt == 0) begin
                    if (nexp[i] == 0) lead[i]++;
                    trail[i]++;
                end else begin
                    trail[i] = 0;
                end
                fd = q[f].data;
                for (int k = 0; k < q[f].cnt; k++) begin
                    exps[i][nexp[i]] = fd[k*SLOT_W +: SLOT_W];
                    nexp[i]++;
                end
            end
        end
        mq0.delete();
        mq1.delete();
        if (pulse) begin
            test_ending = 1'b1;
            step();
            test_ending = 1'b0;
        end
        for (int c = 1; c <= 300; c++) begin
            v[0] = rd_valid0; v[1] = rd_valid1;
            d[0] = rd_data0;  d[1] = rd_data1;
            e[0] = ended0;    e[1] = ended1;
            if (c == 1) begin
                chk("drain_c1_vld0", v[0], 0);
                chk("drain_c1_vld1", v[1], 0);
            end
            for (int i = 0; i < 2; i++) begin
                if (!done[i]) begin
                    if (v[i] && !started[i]) begin
                        started[i] = 1'b1;
                        chk($sformatf("first_vld_cycle%0d", i), c, 2 + lead[i]);
                    end
                    if (held[i]) begin
                        chk($sformatf("hold_vld%0d", i), v[i], 1);
                        chk($sformatf("hold_data%0d", i), d[i], hv[i]);
                    end
                    if (e[i]) begin
                        done[i] = 1'b1;
                        exp_end = (nexp[i] == 0) ? 2 + nfr[i] : last_hs[i] + 1 + trail[i];
                        chk($sformatf("end_cycle%0d", i), c, exp_end);
                        chk($sformatf("slots_read%0d", i), idx[i], nexp[i]);
                        if (i == 0) end_c = c;
                    end
                end
            end
            if (mode == 0)      rd_ready = 1'b1;
            else if (mode == 1) rd_ready = 1'($urandom_range(0, 1));
            else                rd_ready = !(c >= 3 && c <= 7);
            if (mode == 1) begin
                dct_valid   = 1'($urandom_range(0, 1));
                dct_count   = 4'($urandom);
                dct_buffer  = 30'($urandom);
                test_ending = 1'($urandom_range(0, 1));
            end
            for (int i = 0; i < 2; i++) begin
                held[i] = 1'b0;
                if (v[i] && rd_ready && !done[i]) begin
                    if (idx[i] < nexp[i]) chk($sformatf("slot%0d_%0d", i, idx[i]), d[i], exps[i][idx[i]]);
                    else                  chk($sformatf("extra_slot%0d", i), 1, 0);
                    idx[i]++;
                    last_hs[i] = c;
                end else if (v[i] && !done[i]) begin
                    held[i] = 1'b1;
                    hv[i]   = d[i];
                end
            end
            step();
            if (done[0] && done[1]) break;
            if (stop_hs > 0 && idx[0] >= stop_hs) break;
        end
        dct_valid = 1'b0; test_ending = 1'b0; rd_ready = 1'b0;
        if (stop_hs == 0) begin
            chk("drain_done0", done[0], 1);   chk("drain_done1", done[1], 1);
            chk("drain_held0", held0, 0);     chk("drain_held1", held1, 0);
            chk("drain_ovf0", ovf0, movf[0]); chk("drain_ovf1", ovf1, movf[1]);
        end
    endtask

    task automatic cap_six();
        cap(3, {10'h103, 10'h102, 10'h101}, 1'b0);
        cap(1, {10'h3FF, 10'h3FE, 10'h104}, 1'b0);
        cap(2, {10'h3FD, 10'h106, 10'h105}, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int endc, n;
        bit te_done;
        reset = 1'b1; dct_valid = 1'b0; test_ending = 1'b0; rd_ready = 1'b0;
        dct_buffer = '0; dct_count = '0;
        model_clear();

        // Three frames A,B,C / D / E,F read out on consecutive cycles.
        do_reset();
        cap_six();
        drain(1'b1, 0, 0, endc);
        chk("t1_end_cycle", endc, 8);
        test_ending = 1'b1;
        step();
        test_ending = 1'b0;
        step();
        chk("t1_sticky_end0", ended0, 1); chk("t1_sticky_end1", ended1, 1);
        chk("t1_idle_vld0", rd_valid0, 0);

        // Empty buffer ends two cycles after test_ending.
        do_reset();
        drain(1'b1, 0, 0, endc);
        chk("t2_end_cycle", endc, 2);

        // 18 single-slot frames into 16 entries: drop-new vs overwrite-oldest.
        do_reset();
        for (int k = 0; k < 18; k++) cap(1, 30'(k), 1'b0);
        chk("t3_held0", held0, 16); chk("t3_ovf1", ovf1, 1);
        drain(1'b1, 0, 0, endc);

        // Zero-count frame and an over-range count, last frame with test_ending.
        do_reset();
        cap(0, {10'h3AA, 10'h3BB, 10'h3CC}, 1'b0);
        cap(15, {10'h0C3, 10'h0C2, 10'h0C1}, 1'b1);
        drain(1'b0, 0, 0, endc);

        // Backpressure on the second slot.
        do_reset();
        cap_six();
        drain(1'b1, 2, 0, endc);

        // Reset mid-drain after two slots, then a normal run.
        do_reset();
        cap_six();
        drain(1'b1, 0, 2, endc);
        reset = 1'b1;
        step();
        chk("t6_vld0", rd_valid0, 0); chk("t6_held0", held0, 0);
        chk("t6_end0", ended0, 0);    chk("t6_vld1", rd_valid1, 0);
        reset = 1'b0;
        model_clear();
        cap_six();
        drain(1'b1, 0, 0, endc);
        chk("t6_end_cycle", endc, 8);

        // Randomized rounds.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            n = $urandom_range(0, 22);
            te_done = 1'b0;
            for (int k = 0; k < n; k++) begin
                for (int w = $urandom_range(0, 2); w > 0; w--) step();
                te_done = (k == n - 1) && ($urandom_range(0, 1) == 1);
                cap($urandom_range(0, 15), 30'($urandom), te_done);
            end
            drain(!te_done, 1, 0, endc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
